jhash_core: RTL
===============

Name: jhash_core

Overview:
- Jenkins lookup3-style hash engine directly downstream of the jhash input stage.
- Consumes 96-bit blocks (three 32-bit words) over a valid/ack stream, mixes each block into a/b/c state, applies the final avalanche when the stream signals done, and presents a 32-bit hash result.
- Multi-cycle iterative datapath: one mix or final step per cycle; throughput is one block per 7 cycles.

Parameters:
- INITVAL, 32'hdeadbeef, seed loaded into a, b and c at reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- ce  input  1  clock enable; low freezes all state and forces stream_ack low
- stream_data0  input  32  block word 0, added to a
- stream_data1  input  32  block word 1, added to b
- stream_data2  input  32  block word 2, added to c
- stream_valid  input  1  block on stream_data0..2 is valid
- stream_done  input  1  end of message, level, registered by the upstream stage
- stream_left  input  2  upstream word alignment tag, captured into last_left on each accept, not used in arithmetic
- stream_ack  output  1  combinational; block consumed this cycle
- hash_out  output  32  final hash (register c), valid when hash_valid=1
- hash_valid  output  1  hash complete, held until reset
- busy  output  1  high in any MIX or FIN state
- last_left  output  2  stream_left of the most recently accepted block

Behaviour:
- Reset (async, rst=1):
  - a=b=c=INITVAL
  - state=S_IDLE, step counter=0
  - hash_valid=0, busy=0, last_left=0
  - hash_out reflects c, i.e. INITVAL
- States: S_IDLE, S_MIX (6 steps), S_FIN (7 steps), S_DONE. A 3-bit step counter indexes the steps.
- stream_ack = ce & (state==S_IDLE) & stream_valid. It is combinational because the upstream stage samples it in the same cycle to pop its source.
- Accept edge (stream_ack=1):
  - a+=d0, b+=d1, c+=d2, modulo 2^32
  - last_left<=stream_left
  - step<=0, state->S_MIX
- S_MIX: one lookup3 mix row per cycle. Within a row, ops are applied sequentially, each using the results of the previous op. rot = rotate left.
  - step0: a-=c; a^=rot(c,4); c+=b
  - step1: b-=a; b^=rot(a,6); a+=c
  - step2: c-=b; c^=rot(b,8); b+=a
  - step3: a-=c; a^=rot(c,16); c+=b
  - step4: b-=a; b^=rot(a,19); a+=c
  - step5: c-=b; c^=rot(b,4); b+=a, then state->S_IDLE
- S_IDLE with stream_done=1 and stream_valid=0 and ce: step<=0, state->S_FIN.
- Priority: stream_valid beats stream_done when both are high; the block is accepted first and done is taken on a later IDLE cycle.
- S_FIN: one lookup3 final pair per cycle.
  - step0: c^=b; c-=rot(b,14)
  - step1: a^=c; a-=rot(c,11)
  - step2: b^=a; b-=rot(a,25)
  - step3: c^=b; c-=rot(b,16)
  - step4: a^=c; a-=rot(c,4)
  - step5: b^=a; b-=rot(a,14)
  - step6: c^=b; c-=rot(b,24), then state->S_DONE
- S_DONE:
  - hash_valid=1, hash_out=c, stream_ack=0
  - terminal until rst; further stream_valid is ignored
- Latency:
  - last block accept to IDLE: 6 cycles
  - done seen in IDLE to hash_valid high: 8 cycles (1 entry + 7 FIN)
- Zero-block message: stream_done with no accepted block runs FIN on the seed values.
- ce=0 mid-MIX/FIN: state, step and a/b/c hold; the sequence resumes exactly where it stopped.
- rst mid-operation: immediate return to reset values; a partial hash is never presented.
- Arithmetic: all adds/subs are 32-bit wrap-around; no carry is kept.

Test Plan:
- INITVAL=0; one block d0=d1=d2=0; then done -> stream_ack high exactly 1 cycle; busy high 6 cycles; hash_valid rises 8 cycles after done is sampled in IDLE; hash_out=32'h0.
- INITVAL=32'hdeadbeef; blocks {1,2,3} and {4,5,6} held valid continuously -> acks spaced exactly 7 cycles apart; last_left tracks stream_left (2'b10 then 2'b01); hash_out equals the C lookup3 golden model (mix every block, final at end).
- Zero-block message: done only -> hash_out equals the golden final(INITVAL,INITVAL,INITVAL); no ack ever asserted.
- stream_valid and stream_done asserted together in IDLE -> block accepted first; FIN starts only after MIX completes; hash matches the golden model including that block.
- ce low for 5 cycles at MIX step 3 and again at FIN step 2 -> a/b/c frozen; stream_ack=0 throughout; final hash identical to the ce-always-high run, delayed by 10 cycles.
- rst pulse during FIN step 4 -> hash_valid=0, a=b=c=INITVAL asynchronously; a new message after reset hashes identically to the same message run from power-up.

Source files
------------

// File: rtl/jhash_core.sv
// rtl/jhash_core.sv - lookup3-style iterative hash engine
// Mixes 96-bit blocks into a/b/c one row per cycle, then runs the final avalanche on done.
module jhash_core #(
    parameter logic [31:0] INITVAL = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] stream_data0,
    input  logic [31:0] stream_data1,
    input  logic [31:0] stream_data2,
    input  logic        stream_valid,
    input  logic        stream_done,
    input  logic [1:0]  stream_left,
    output logic        stream_ack,
    output logic [31:0] hash_out,
    output logic        hash_valid,
    output logic        busy,
    output logic [1:0]  last_left
);
    typedef enum logic [1:0] {S_IDLE, S_MIX, S_FIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]  last_left_q, last_left_d;
    logic        hash_valid_q, hash_valid_d;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] k);
        return (x << k) | (x >> (6'd32 - {1'b0, k}));
    endfunction

    // Upstream pops its source in the same cycle, so ack cannot be registered.
    assign stream_ack = ce & (state_q == S_IDLE) & stream_valid;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        last_left_d  = last_left_q;
        hash_valid_d = hash_valid_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (stream_valid) begin
                        a_d         = a_q + stream_data0;
                        b_d         = b_q + stream_data1;
                        c_d         = c_q + stream_data2;
                        last_left_d = stream_left;
                        step_d      = 3'd0;
                        state_d     = S_MIX;
                    end else if (stream_done) begin
                        step_d  = 3'd0;
                        state_d = S_FIN;
                    end
                end
                S_MIX: begin
                    case (step_q)
                        3'd0: begin a_d = (a_q - c_q) ^ rotl(c_q, 5'd4);  c_d = c_q + b_q; end
                        3'd1: begin b_d = (b_q - a_q) ^ rotl(a_q, 5'd6);  a_d = a_q + c_q; end
                        3'd2: begin c_d = (c_q - b_q) ^ rotl(b_q, 5'd8);  b_d = b_q + a_q; end
                        3'd3: begin a_d = (a_q - c_q) ^ rotl(c_q, 5'd16); c_d = c_q + b_q; end
                        3'd4: begin b_d = (b_q - a_q) ^ rotl(a_q, 5'd19); a_d = a_q + c_q; end
                        default: begin c_d = (c_q - b_q) ^ rotl(b_q, 5'd4); b_d = b_q + a_q; end
                    endcase
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd5) begin
                        step_d  = 3'd0;
                        state_d = S_IDLE;
                    end
                end
                S_FIN: begin
                    case (step_q)
                        3'd0: c_d = (c_q ^ b_q) - rotl(b_q, 5'd14);
                        3'd1: a_d = (a_q ^ c_q) - rotl(c_q, 5'd11);
                        3'd2: b_d = (b_q ^ a_q) - rotl(a_q, 5'd25);
                        3'd3: c_d = (c_q ^ b_q) - rotl(b_q, 5'd16);
                        3'd4: a_d = (a_q ^ c_q) - rotl(c_q, 5'd4);
                        3'd5: b_d = (b_q ^ a_q) - rotl(a_q, 5'd14);
                        default: c_d = (c_q ^ b_q) - rotl(b_q, 5'd24);
                    endcase
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd6) begin
                        step_d       = 3'd0;
                        state_d      = S_DONE;
                        hash_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= 3'd0;
            a_q          <= INITVAL;
            b_q          <= INITVAL;
            c_q          <= INITVAL;
            last_left_q  <= 2'd0;
            hash_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            last_left_q  <= last_left_d;
            hash_valid_q <= hash_valid_d;
        end
    end

    assign hash_out   = c_q;
    assign hash_valid = hash_valid_q;
    assign busy       = (state_q == S_MIX) || (state_q == S_FIN);
    assign last_left  = last_left_q;
endmodule
